// File: rtl/point_integrator_pkg.sv
// Shared physics definitions for the spring/integrator pipeline:
// integrator state encoding plus default datapath widths and shift constants.
package point_integrator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INTEGRATE,
        DONE
    } state_t;

    localparam int DEF_POSITION_SIZE = 16;
    localparam int DEF_VELOCITY_SIZE = 16;
    localparam int DEF_FORCE_SIZE    = 24;
    localparam int DEF_F2V_SHIFT     = 4;
    localparam int DEF_V2P_SHIFT     = 2;
    localparam int DEF_GRAVITY       = -8;

    // Headroom above FORCE_SIZE so many springs can pile onto one point.
    localparam int ACC_GUARD_BITS    = 4;

endpackage

// File: rtl/point_integrator_sat_add.sv
// Signed saturating adder: adds two IN_W operands exactly, then clamps the
// result into the signed OUT_W range instead of wrapping (OUT_W <= IN_W+1).
module sat_add #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [OUT_W-1:0] y
);

    logic signed [IN_W:0] sum;

    assign sum = (IN_W+1)'(a) + (IN_W+1)'(b);

    // In range only if every bit above the OUT_W sign bit copies the true sign.
    always_comb begin
        y = sum[OUT_W-1:0];
        if (sum[IN_W:OUT_W-1] != {(IN_W-OUT_W+2){sum[IN_W]}}) begin
            y = {sum[IN_W], {(OUT_W-1){~sum[IN_W]}}};
        end
    end

endmodule

// File: rtl/point_integrator.sv
// Point-mass integrator: accumulates spring forces per point while idle, then
// sweeps all points once per step, updating velocity and position with floor clamp.
module point_integrator
    import point_integrator_pkg::*;
#(
    parameter int NUM_POINTS    = 8,
    parameter int POSITION_SIZE = DEF_POSITION_SIZE,
    parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
    parameter int FORCE_SIZE    = DEF_FORCE_SIZE,
    parameter int F2V_SHIFT     = DEF_F2V_SHIFT,
    parameter int V2P_SHIFT     = DEF_V2P_SHIFT,
    parameter logic signed [FORCE_SIZE-1:0]    GRAVITY = FORCE_SIZE'(DEF_GRAVITY),
    parameter logic signed [POSITION_SIZE-1:0] FLOOR_Y = '0
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  init_valid_in,
    input  logic [$clog2(NUM_POINTS)-1:0]         init_idx_in,
    input  logic signed [POSITION_SIZE-1:0]       init_x_in,
    input  logic signed [POSITION_SIZE-1:0]       init_y_in,
    input  logic                                  force_valid_in,
    output logic                                  force_ready_out,
    input  logic [$clog2(NUM_POINTS)-1:0]         force_idx_in,
    input  logic signed [FORCE_SIZE-1:0]          force_x_in,
    input  logic signed [FORCE_SIZE-1:0]          force_y_in,
    input  logic                                  step_in,
    output logic                                  busy_out,
    output logic                                  step_done_out,
    input  logic [$clog2(NUM_POINTS)-1:0]         rd_idx_in,
    output logic signed [POSITION_SIZE-1:0]       rd_pos_x_out,
    output logic signed [POSITION_SIZE-1:0]       rd_pos_y_out,
    output logic signed [VELOCITY_SIZE-1:0]       rd_vel_x_out,
    output logic signed [VELOCITY_SIZE-1:0]       rd_vel_y_out
);

    localparam int IDX_W = $clog2(NUM_POINTS);
    localparam int AW    = FORCE_SIZE + ACC_GUARD_BITS;
    localparam int PIW   = (POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE;
    localparam logic [IDX_W:0]   NP   = (IDX_W+1)'(NUM_POINTS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_POINTS - 1);

    state_t state, state_nxt;
    logic [IDX_W-1:0] ptr;

    logic signed [POSITION_SIZE-1:0] pos_x [NUM_POINTS];
    logic signed [POSITION_SIZE-1:0] pos_y [NUM_POINTS];
    logic signed [VELOCITY_SIZE-1:0] vel_x [NUM_POINTS];
    logic signed [VELOCITY_SIZE-1:0] vel_y [NUM_POINTS];
    logic signed [AW-1:0]            acc_x [NUM_POINTS];
    logic signed [AW-1:0]            acc_y [NUM_POINTS];

    logic init_ok, force_ok;
    logic signed [AW-1:0] acc_x_sel, acc_y_sel, acc_x_add, acc_y_add;
    logic signed [AW-1:0] acc_y_grav, dv_x, dv_y;
    logic signed [VELOCITY_SIZE-1:0] vel_x_new, vel_y_new;
    logic signed [POSITION_SIZE-1:0] pos_x_new, pos_y_new;
    logic floor_hit;

    assign init_ok  = init_valid_in  && ({1'b0, init_idx_in}  < NP);
    assign force_ok = force_valid_in && ({1'b0, force_idx_in} < NP);

    // Force accumulation path (only committed while idle)
    assign acc_x_sel = force_ok ? acc_x[force_idx_in] : '0;
    assign acc_y_sel = force_ok ? acc_y[force_idx_in] : '0;

    sat_add #(.IN_W(AW), .OUT_W(AW)) u_acc_x (
        .a(acc_x_sel), .b(AW'(force_x_in)), .y(acc_x_add)
    );
    sat_add #(.IN_W(AW), .OUT_W(AW)) u_acc_y (
        .a(acc_y_sel), .b(AW'(force_y_in)), .y(acc_y_add)
    );

    // Integration path for the point selected by ptr
    sat_add #(.IN_W(AW), .OUT_W(AW)) u_grav (
        .a(acc_y[ptr]), .b(AW'(GRAVITY)), .y(acc_y_grav)
    );

    assign dv_x = acc_x[ptr] >>> F2V_SHIFT;
    assign dv_y = acc_y_grav >>> F2V_SHIFT;

    sat_add #(.IN_W(AW), .OUT_W(VELOCITY_SIZE)) u_vel_x (
        .a(AW'(vel_x[ptr])), .b(dv_x), .y(vel_x_new)
    );
    sat_add #(.IN_W(AW), .OUT_W(VELOCITY_SIZE)) u_vel_y (
        .a(AW'(vel_y[ptr])), .b(dv_y), .y(vel_y_new)
    );

    sat_add #(.IN_W(PIW), .OUT_W(POSITION_SIZE)) u_pos_x (
        .a(PIW'(pos_x[ptr])), .b(PIW'(vel_x_new >>> V2P_SHIFT)), .y(pos_x_new)
    );
    sat_add #(.IN_W(PIW), .OUT_W(POSITION_SIZE)) u_pos_y (
        .a(PIW'(pos_y[ptr])), .b(PIW'(vel_y_new >>> V2P_SHIFT)), .y(pos_y_new)
    );

    assign floor_hit = pos_y_new < FLOOR_Y;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An init in the same cycle wins over a step request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (step_in && !init_valid_in) state_nxt = INTEGRATE;
            INTEGRATE: if (ptr == LAST) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        force_ready_out = (state == IDLE);
        busy_out        = (state != IDLE);
        step_done_out   = (state == DONE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < NUM_POINTS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                vel_x[i] <= '0;
                vel_y[i] <= '0;
                acc_x[i] <= '0;
                acc_y[i] <= '0;
            end
            ptr          <= '0;
            rd_pos_x_out <= '0;
            rd_pos_y_out <= '0;
            rd_vel_x_out <= '0;
            rd_vel_y_out <= '0;
        end else begin
            if ({1'b0, rd_idx_in} < NP) begin
                rd_pos_x_out <= pos_x[rd_idx_in];
                rd_pos_y_out <= pos_y[rd_idx_in];
                rd_vel_x_out <= vel_x[rd_idx_in];
                rd_vel_y_out <= vel_y[rd_idx_in];
            end else begin
                rd_pos_x_out <= '0;
                rd_pos_y_out <= '0;
                rd_vel_x_out <= '0;
                rd_vel_y_out <= '0;
            end

            case (state)
                IDLE: begin
                    ptr <= '0;
                    if (force_ok) begin
                        acc_x[force_idx_in] <= acc_x_add;
                        acc_y[force_idx_in] <= acc_y_add;
                    end
                    // Placed after the force update so an init clears a same-cycle force.
                    if (init_ok) begin
                        pos_x[init_idx_in] <= init_x_in;
                        pos_y[init_idx_in] <= init_y_in;
                        vel_x[init_idx_in] <= '0;
                        vel_y[init_idx_in] <= '0;
                        acc_x[init_idx_in] <= '0;
                        acc_y[init_idx_in] <= '0;
                    end
                end
                INTEGRATE: begin
                    vel_x[ptr] <= vel_x_new;
                    pos_x[ptr] <= pos_x_new;
                    if (floor_hit) begin
                        pos_y[ptr] <= FLOOR_Y;
                        vel_y[ptr] <= '0;
                    end else begin
                        pos_y[ptr] <= pos_y_new;
                        vel_y[ptr] <= vel_y_new;
                    end
                    acc_x[ptr] <= '0;
                    acc_y[ptr] <= '0;
                    ptr        <= ptr + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_point_integrator.sv
// Scoreboard bench for point_integrator: one instance without gravity, one with
// GRAVITY=-8, both fed identical stimulus and checked against a behavioural model.
module tb_point_integrator;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 28;

    typedef logic [63:0] pt_t;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                 rst_in, init_valid_in, force_valid_in, step_in;
    logic [IW-1:0]        init_idx_in, force_idx_in, rd_idx_in;
    logic signed [15:0]   init_x_in, init_y_in;
    logic signed [23:0]   force_x_in, force_y_in;

    logic                 ready, busy, done;
    logic signed [15:0]   rpx, rpy, rvx, rvy;
    logic                 g_ready, g_busy, g_done;
    logic signed [15:0]   g_rpx, g_rpy, g_rvx, g_rvy;

    point_integrator #(
        .NUM_POINTS(N), .F2V_SHIFT(4), .V2P_SHIFT(0), .GRAVITY(24'sd0)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .init_valid_in(init_valid_in), .init_idx_in(init_idx_in),
        .init_x_in(init_x_in), .init_y_in(init_y_in),
        .force_valid_in(force_valid_in), .force_ready_out(ready),
        .force_idx_in(force_idx_in), .force_x_in(force_x_in), .force_y_in(force_y_in),
        .step_in(step_in), .busy_out(busy), .step_done_out(done),
        .rd_idx_in(rd_idx_in),
        .rd_pos_x_out(rpx), .rd_pos_y_out(rpy), .rd_vel_x_out(rvx), .rd_vel_y_out(rvy)
    );

    point_integrator #(
        .NUM_POINTS(N), .F2V_SHIFT(4), .V2P_SHIFT(0), .GRAVITY(-24'sd8)
    ) dut_g (
        .clk_in(clk_in), .rst_in(rst_in),
        .init_valid_in(init_valid_in), .init_idx_in(init_idx_in),
        .init_x_in(init_x_in), .init_y_in(init_y_in),
        .force_valid_in(force_valid_in), .force_ready_out(g_ready),
        .force_idx_in(force_idx_in), .force_x_in(force_x_in), .force_y_in(force_y_in),
        .step_in(step_in), .busy_out(g_busy), .step_done_out(g_done),
        .rd_idx_in(rd_idx_in),
        .rd_pos_x_out(g_rpx), .rd_pos_y_out(g_rpy), .rd_vel_x_out(g_rvx), .rd_vel_y_out(g_rvy)
    );

    int n_cmp = 0;
    int n_fail = 0;

    longint m_px [2][N];
    longint m_py [2][N];
    longint m_vx [2][N];
    longint m_vy [2][N];
    longint m_ax [2][N];
    longint m_ay [2][N];
    longint grav [2] = '{0, -8};

    pt_t exp_q [$];
    pt_t act_q [$];

    function automatic longint clamp(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < N; p++) begin
                m_px[d][p] = 0; m_py[d][p] = 0; m_vx[d][p] = 0;
                m_vy[d][p] = 0; m_ax[d][p] = 0; m_ay[d][p] = 0;
            end
    endtask

    task automatic model_step();
        longint ty;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < N; p++) begin
                ty = clamp(m_ay[d][p] + grav[d], AW);
                m_vx[d][p] = clamp(m_vx[d][p] + (m_ax[d][p] >>> 4), 16);
                m_vy[d][p] = clamp(m_vy[d][p] + (ty >>> 4), 16);
                m_px[d][p] = clamp(m_px[d][p] + m_vx[d][p], 16);
                m_py[d][p] = clamp(m_py[d][p] + m_vy[d][p], 16);
                if (m_py[d][p] < 0) begin
                    m_py[d][p] = 0;
                    m_vy[d][p] = 0;
                end
                m_ax[d][p] = 0;
                m_ay[d][p] = 0;
            end
    endtask

    task automatic do_init(input int idx, input longint x, input longint y);
        init_valid_in = 1'b1; init_idx_in = IW'(idx);
        init_x_in = 16'(x); init_y_in = 16'(y);
        tick();
        init_valid_in = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_px[d][idx] = x; m_py[d][idx] = y; m_vx[d][idx] = 0;
            m_vy[d][idx] = 0; m_ax[d][idx] = 0; m_ay[d][idx] = 0;
        end
    endtask

    task automatic do_force(input int idx, input longint fx, input longint fy, input bit accept);
        force_valid_in = 1'b1; force_idx_in = IW'(idx);
        force_x_in = 24'(fx); force_y_in = 24'(fy);
        tick();
        force_valid_in = 1'b0;
        if (accept)
            for (int d = 0; d < 2; d++) begin
                m_ax[d][idx] = clamp(m_ax[d][idx] + fx, AW);
                m_ay[d][idx] = clamp(m_ay[d][idx] + fy, AW);
            end
    endtask

    task automatic start_step();
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
        model_step();
    endtask

    // Returns how many cycles after the accepted step the done pulse appeared.
    task automatic wait_done(output int cycles, output bit seen);
        cycles = 1;
        seen = 1'b0;
        while (cycles <= 20 && !seen) begin
            if (done && g_done) seen = 1'b1;
            else begin
                tick();
                cycles++;
            end
        end
        if (seen) tick();
    endtask

    task automatic read_point(input int idx);
        rd_idx_in = IW'(idx);
        for (int d = 0; d < 2; d++)
            exp_q.push_back({16'(m_px[d][idx]), 16'(m_py[d][idx]),
                             16'(m_vx[d][idx]), 16'(m_vy[d][idx])});
        tick();
        act_q.push_back({rpx, rpy, rvx, rvy});
        act_q.push_back({g_rpx, g_rpy, g_rvx, g_rvy});
    endtask

    task automatic test_reset();
        pt_t e, a;
        rst_in = 1'b1; init_valid_in = 0; force_valid_in = 0; step_in = 0;
        init_idx_in = 0; force_idx_in = 0; rd_idx_in = 0;
        init_x_in = 0; init_y_in = 0; force_x_in = 0; force_y_in = 0;
        tick(); tick();
        rst_in = 1'b0;
        model_reset();
        n_cmp++;
        if ({busy, g_busy, done, g_done, ready, g_ready} !== 6'b000011) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/ready got %b want 000011",
                     {busy, g_busy, done, g_done, ready, g_ready});
        end
        for (int p = 0; p < N; p++) read_point(p);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin n_fail++; $display("FAIL reset_read: got %h want %h", a, e); end
        end
    endtask

    task automatic test_basic();
        pt_t e, a; int cyc; bit seen;
        do_init(0, 100, 200);
        do_force(0, 32, 0, 1'b1);
        start_step();
        n_cmp++;
        if (!(busy === 1'b1 && ready === 1'b0)) begin
            n_fail++; $display("FAIL basic_busy: busy %b ready %b want 1 0", busy, ready);
        end
        wait_done(cyc, seen);
        n_cmp++;
        if (!seen || cyc != N + 1) begin
            n_fail++; $display("FAIL basic_latency: seen %0d cycles %0d want 1 %0d", seen, cyc, N + 1);
        end
        read_point(0);
        n_cmp++;
        if ({rpx, rpy, rvx, rvy} !== {16'sd102, 16'sd200, 16'sd2, 16'sd0}) begin
            n_fail++; $display("FAIL basic_const: got %0d %0d %0d %0d want 102 200 2 0", rpx, rpy, rvx, rvy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin n_fail++; $display("FAIL basic_pt0: got %h want %h", a, e); end
        end
    endtask

    task automatic test_neg_shift();
        pt_t e, a; int cyc; bit seen;
        do_init(2, 50, 50);
        do_force(2, 16, 0, 1'b1);
        do_force(2, -48, 0, 1'b1);
        start_step();
        wait_done(cyc, seen);
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL neg_done: no step_done within 20 cycles (got %0d)", cyc); end
        read_point(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin n_fail++; $display("FAIL neg_shift_pt2: got %h want %h", a, e); end
        end
    endtask

    task automatic test_floor();
        pt_t e, a; int cyc; bit seen;
        do_init(1, 0, 1);
        do_force(1, 0, -48, 1'b1);
        start_step();
        wait_done(cyc, seen);
        read_point(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin n_fail++; $display("FAIL floor_pt1: got %h want %h", a, e); end
        end
    endtask

    task automatic test_drop();
        pt_t e, a; int cyc; bit seen;
        do_init(3, 0, 0);
        start_step();
        n_cmp++;
        if (ready !== 1'b0 || g_ready !== 1'b0) begin
            n_fail++; $display("FAIL drop_ready: got %b %b want 0 0", ready, g_ready);
        end
        do_force(3, 160, 0, 1'b0);
        wait_done(cyc, seen);
        start_step();
        wait_done(cyc, seen);
        n_cmp++;
        if (!seen || cyc != N + 1) begin
            n_fail++; $display("FAIL drop_latency: seen %0d cycles %0d want 1 %0d", seen, cyc, N + 1);
        end
        read_point(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin n_fail++; $display("FAIL drop_pt3: got %h want %h", a, e); end
        end
    endtask

    task automatic test_back_to_back();
        pt_t e, a; int cyc; bit seen;
        // init and step together: step must be ignored
        init_valid_in = 1'b1; init_idx_in = 2'd1; init_x_in = 16'sd5; init_y_in = 16'sd300;
        step_in = 1'b1;
        tick();
        init_valid_in = 1'b0; step_in = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_px[d][1] = 5; m_py[d][1] = 300; m_vx[d][1] = 0;
            m_vy[d][1] = 0; m_ax[d][1] = 0; m_ay[d][1] = 0;
        end
        n_cmp++;
        if (busy !== 1'b0 || g_busy !== 1'b0) begin
            n_fail++; $display("FAIL init_prio: busy got %b %b want 0 0", busy, g_busy);
        end
        // force and step together: force belongs to this pass
        force_valid_in = 1'b1; force_idx_in = 2'd1; force_x_in = 24'sd64; force_y_in = 24'sd0;
        step_in = 1'b1;
        tick();
        force_valid_in = 1'b0; step_in = 1'b0;
        for (int d = 0; d < 2; d++) m_ax[d][1] = 64;
        model_step();
        wait_done(cyc, seen);
        n_cmp++;
        if (!seen || cyc != N + 1) begin
            n_fail++; $display("FAIL b2b_latency: seen %0d cycles %0d want 1 %0d", seen, cyc, N + 1);
        end
        for (int p = 0; p < N; p++) read_point(p);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin n_fail++; $display("FAIL b2b_read: got %h want %h", a, e); end
        end
    endtask

    task automatic test_gravity();
        pt_t e, a; int cyc; bit seen;
        do_init(0, 0, 1000);
        repeat (20) do_force(0, 0, -(longint'(1) <<< 23), 1'b1);
        start_step();
        wait_done(cyc, seen);
        read_point(0);
        n_cmp++;
        if (g_rpy !== 16'sd0 || g_rvy !== 16'sd0) begin
            n_fail++; $display("FAIL grav_const: pos_y %0d vel_y %0d want 0 0", g_rpy, g_rvy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin n_fail++; $display("FAIL grav_pt0: got %h want %h", a, e); end
        end
    endtask

    task automatic test_mid_reset();
        pt_t e, a; int pulses;
        start_step();
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        model_reset();
        n_cmp++;
        if ({busy, g_busy, done, g_done} !== 4'b0000 ||
            {rpx, rpy, rvx, rvy} !== 64'd0 || {g_rpx, g_rpy, g_rvx, g_rvy} !== 64'd0) begin
            n_fail++;
            $display("FAIL midrst_state: busy/done %b reads %h %h want 0000 0 0",
                     {busy, g_busy, done, g_done}, {rpx, rpy, rvx, rvy}, {g_rpx, g_rpy, g_rvx, g_rvy});
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || g_done) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 0) begin n_fail++; $display("FAIL midrst_done: pulses %0d want 0", pulses); end
        for (int p = 0; p < N; p++) read_point(p);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin n_fail++; $display("FAIL midrst_read: got %h want %h", a, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_neg_shift();
        test_floor();
        test_drop();
        test_back_to_back();
        test_gravity();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
